// File: rtl/display_pkg.sv
// display_pkg: shared types and helpers for the multi-source display front end.
//   mode_e       : what the display shows (live value, snapshot, running min or max)
//   conv_state_e : conversion FSM state, also exported for debug
//   BCD_DIGITS   : number of BCD digits needed for an unsigned w-bit value
package display_pkg;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    HOLD = 2'd1,
    MIN  = 2'd2,
    MAX  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // ceil(w * log10(2)), with log10(2) approximated as 0.30103 in fixed point.
  function automatic int BCD_DIGITS(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_iter.sv
// bcd_iter: iterative double-dabble binary-to-BCD converter.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load bin and clear the BCD accumulator (one-cycle strobe)
//   bin          : W-bit unsigned input, sampled on start
//   bcd          : D BCD digits, digit 0 in bcd[3:0]
//   done         : high during the cycle whose step is the last one; bcd is
//                  final from the following cycle until the next start
// One step per cycle after start: add 3 to every nibble >= 5, then shift the
// next binary bit in from the top of the input shift register.
module bcd_iter
  import display_pkg::*;
#(
  parameter int W = 13,
  parameter int D = BCD_DIGITS(W)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic [4*D-1:0] bcd,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   sr;
  logic [CW-1:0]  step_cnt;
  logic           active;
  logic [4*D-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = active && (step_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      bcd      <= '0;
      step_cnt <= '0;
      active   <= 1'b0;
    end else if (start) begin
      sr       <= bin;
      bcd      <= '0;
      step_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      bcd      <= {adj[4*D-2:0], sr[W-1]};
      sr       <= sr << 1;
      step_cnt <= step_cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_source_display_ctrl.sv
// multi_source_display_ctrl: selects one of NUM_SRC sources, shows its live
// value, a captured snapshot, or its running min/max, and converts it to hex
// nibbles or decimal BCD on a fixed refresh tick.
//   clk, reset_n : clock, asynchronous active-low reset
//   src_data     : packed sources, source i at [i*DATA_W +: DATA_W]
//   src_sel      : source select (out-of-range selects source 0)
//   mode         : LIVE/HOLD/MIN/MAX, sampled on tick
//   hold_pulse   : capture live value into the snapshot
//   clear_pulse  : restart min/max tracking
//   digits       : NUM_DIGITS nibbles, digit 0 least significant
//   blank        : per-digit blank, active high
//   valid        : one-cycle pulse in the cycle digits/blank/ovf take a new
//                  value; there is no back-pressure, the consumer must take it
//   busy         : conversion in progress (SHIFT or DONE)
//   ovf          : decimal value does not fit in NUM_DIGITS digits
//   dbg_state    : current conversion FSM state
module multi_source_display_ctrl
  import display_pkg::*;
#(
  parameter int                 NUM_SRC    = 4,
  parameter int                 DATA_W     = 13,
  parameter int                 NUM_DIGITS = 4,
  parameter logic [NUM_SRC-1:0] DEC_MASK   = NUM_SRC'(4'b0011),
  parameter int                 UPDATE_DIV = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [$clog2(NUM_SRC)-1:0]  src_sel,
  input  logic [1:0]                  mode,
  input  logic                        hold_pulse,
  input  logic                        clear_pulse,
  output logic [NUM_DIGITS*4-1:0]     digits,
  output logic [NUM_DIGITS-1:0]       blank,
  output logic                        valid,
  output logic                        busy,
  output logic                        ovf,
  output logic [1:0]                  dbg_state
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int BCD_D = BCD_DIGITS(DATA_W);
  localparam int HEX_D = (DATA_W + 3) / 4;
  localparam int MAX_A = (NUM_DIGITS > BCD_D) ? NUM_DIGITS : BCD_D;
  localparam int EXT_D = (MAX_A > HEX_D) ? MAX_A : HEX_D;
  localparam int TW    = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] RST_BLANK = ~(NUM_DIGITS'(1));

  // ---------------- source selection ----------------
  logic [SEL_W-1:0]  sel_c, sel_q;
  logic [DATA_W-1:0] live_val;
  mode_e             mode_c;

  assign sel_c    = (int'(src_sel) < NUM_SRC) ? src_sel : '0;
  assign live_val = src_data[int'(sel_c)*DATA_W +: DATA_W];
  assign mode_c   = mode_e'(mode);

  // ---------------- refresh tick ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(UPDATE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // ---------------- snapshot and min/max ----------------
  logic [DATA_W-1:0] snap_q, min_q, max_q, min_nxt, max_nxt;
  logic              first, first_eff;

  // A clear or a source change in the tick cycle itself already restarts
  // tracking for that tick.
  assign first_eff = first | clear_pulse | (sel_c != sel_q);
  assign min_nxt   = (first_eff || live_val < min_q) ? live_val : min_q;
  assign max_nxt   = (first_eff || live_val > max_q) ? live_val : max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= '0;
      snap_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
      first  <= 1'b1;
    end else begin
      sel_q <= sel_c;
      if (hold_pulse) snap_q <= live_val;
      if (tick) begin
        min_q <= min_nxt;
        max_q <= max_nxt;
        first <= 1'b0;
      end else begin
        first <= first_eff;
      end
    end
  end

  // Displayed value includes the current tick's min/max update.
  logic [DATA_W-1:0] disp_val;

  always_comb begin
    disp_val = live_val;
    case (mode_c)
      LIVE:    disp_val = live_val;
      HOLD:    disp_val = snap_q;
      MIN:     disp_val = min_nxt;
      MAX:     disp_val = max_nxt;
      default: disp_val = live_val;
    endcase
  end

  // ---------------- conversion FSM ----------------
  conv_state_e       state;
  logic [DATA_W-1:0] val_q;
  logic              dec_q;
  logic              bcd_start, bcd_done;
  logic [4*BCD_D-1:0] bcd_val;

  assign bcd_start = (state == IDLE) && tick && DEC_MASK[sel_c];
  assign busy      = (state == SHIFT) || (state == DONE);
  assign dbg_state = state;

  bcd_iter #(.W(DATA_W), .D(BCD_D)) u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bcd_start),
    .bin     (disp_val),
    .bcd     (bcd_val),
    .done    (bcd_done)
  );

  // ---------------- output formatting ----------------
  logic [4*EXT_D-1:0]      hex_ext, bcd_ext;
  logic [NUM_DIGITS*4-1:0] fmt_digits;
  logic [NUM_DIGITS-1:0]   fmt_blank;
  logic                    fmt_ovf;
  logic                    seen_nz;

  assign hex_ext = (4*EXT_D)'(val_q);
  assign bcd_ext = (4*EXT_D)'(bcd_val);

  always_comb begin
    fmt_digits = '0;
    fmt_blank  = '0;
    fmt_ovf    = 1'b0;
    seen_nz    = 1'b0;
    if (!dec_q) begin
      fmt_digits = hex_ext[NUM_DIGITS*4-1:0];
      for (int i = 0; i < NUM_DIGITS; i++) fmt_blank[i] = (i >= HEX_D);
    end else begin
      fmt_digits = bcd_ext[NUM_DIGITS*4-1:0];
      for (int i = NUM_DIGITS; i < EXT_D; i++) begin
        if (bcd_ext[4*i +: 4] != 4'd0) fmt_ovf = 1'b1;
      end
      // Blank zeros above the top nonzero digit; digit 0 always shown, and an
      // overflowing value is shown unblanked.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        seen_nz      = seen_nz | (bcd_ext[4*i +: 4] != 4'd0);
        fmt_blank[i] = ~seen_nz & ~fmt_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      val_q  <= '0;
      dec_q  <= 1'b0;
      digits <= '0;
      blank  <= RST_BLANK;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            val_q <= disp_val;
            dec_q <= DEC_MASK[sel_c];
            state <= DEC_MASK[sel_c] ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          if (bcd_done) state <= DONE;
        end
        DONE: begin
          digits <= fmt_digits;
          blank  <= fmt_blank;
          ovf    <= fmt_ovf;
          valid  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_source_display_ctrl.sv
module tb_multi_source_display_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // main instance: base parameters
  logic [51:0] src_data;
  logic [1:0]  src_sel, mode;
  logic        hold_pulse, clear_pulse;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        valid, busy, ovf;
  logic [1:0]  dbg_state;

  // second instance: 3 digits, fast tick so a tick lands inside SHIFT
  logic [51:0] src_data3;
  logic [1:0]  src_sel3, mode3;
  logic        hold3, clear3;
  logic [11:0] digits3;
  logic [2:0]  blank3;
  logic        valid3, busy3, ovf3;
  logic [1:0]  dbg_state3;

  multi_source_display_ctrl #(
    .NUM_SRC(4), .DATA_W(13), .NUM_DIGITS(4), .DEC_MASK(4'b0011), .UPDATE_DIV(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
    .mode(mode), .hold_pulse(hold_pulse), .clear_pulse(clear_pulse),
    .digits(digits), .blank(blank), .valid(valid), .busy(busy), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  multi_source_display_ctrl #(
    .NUM_SRC(4), .DATA_W(13), .NUM_DIGITS(3), .DEC_MASK(4'b0011), .UPDATE_DIV(8)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .src_data(src_data3), .src_sel(src_sel3),
    .mode(mode3), .hold_pulse(hold3), .clear_pulse(clear3),
    .digits(digits3), .blank(blank3), .valid(valid3), .busy(busy3), .ovf(ovf3),
    .dbg_state(dbg_state3)
  );

  // Cycle index since reset release; equals the expected tick counter value.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  logic [15:0] got_digits;
  logic [3:0]  got_blank;
  logic        got_ovf;
  logic [11:0] got3_digits;
  logic [2:0]  got3_blank;
  logic        got3_ovf;

  // ---------------- driver tasks ----------------
  task automatic set_src(input int idx, input logic [12:0] v);
    src_data[idx*13 +: 13] = v;
  endtask

  task automatic pulse(input bit h, input bit c);
    hold_pulse  = h;
    clear_pulse = c;
    @(negedge clk);
    hold_pulse  = 1'b0;
    clear_pulse = 1'b0;
  endtask

  // Wait for the next tick cycle of the main instance, then for valid.
  // lat = cycles from tick to valid, -1 on timeout.
  task automatic do_conv(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while ((cyc % 32) != 31 && n < 64) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        got_digits = digits;
        got_blank  = blank;
        got_ovf    = ovf;
        break;
      end
    end
  endtask

  // Wait for an accepted tick of the second instance and watch the next 16
  // cycles: vcount valid pulses, first at lat, busy sampled at tick+8.
  task automatic do_conv3(output int lat, output int vcount, output logic busy8);
    int n;
    n      = 0;
    lat    = -1;
    vcount = 0;
    busy8  = 1'b0;
    while ((cyc % 16) != 7 && n < 64) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 8) busy8 = busy3;
      if (valid3) begin
        vcount++;
        if (lat < 0) begin
          lat = i;
          got3_digits = digits3;
          got3_blank  = blank3;
          got3_ovf    = ovf3;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0); end
    total++; if (blank !== 4'b1110) begin bad++; $display("FAIL reset_blank got=%b exp=%b", blank, 4'b1110); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if (blank3 !== 3'b110) begin bad++; $display("FAIL reset_blank3 got=%b exp=%b", blank3, 3'b110); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL pre_tick_idle got busy=%b valid=%b exp 0 0", busy, valid); end
  endtask

  task automatic test_decimal_live;
    int lat;
    src_sel = 2'd0; mode = 2'd0; set_src(0, 13'd1234);
    do_conv(lat);
    total++; if (lat !== 15) begin bad++; $display("FAIL dec_latency got=%0d exp=15", lat); end
    total++; if (got_digits !== 16'h1234) begin bad++; $display("FAIL dec_1234_digits got=%h exp=1234", got_digits); end
    total++; if (got_blank !== 4'b0000) begin bad++; $display("FAIL dec_1234_blank got=%b exp=0000", got_blank); end
    total++; if (got_ovf !== 1'b0) begin bad++; $display("FAIL dec_1234_ovf got=%b exp=0", got_ovf); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got=%b exp=0", valid); end
    set_src(0, 13'd7);
    do_conv(lat);
    total++; if (got_digits !== 16'h0007) begin bad++; $display("FAIL dec_7_digits got=%h exp=0007", got_digits); end
    total++; if (got_blank !== 4'b1110) begin bad++; $display("FAIL dec_7_blank got=%b exp=1110", got_blank); end
  endtask

  task automatic test_hex;
    int lat;
    src_sel = 2'd2; set_src(2, 13'h0ABC);
    do_conv(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL hex_latency got=%0d exp=2", lat); end
    total++; if (got_digits !== 16'h0ABC) begin bad++; $display("FAIL hex_abc_digits got=%h exp=0abc", got_digits); end
    total++; if (got_blank !== 4'b0000) begin bad++; $display("FAIL hex_abc_blank got=%b exp=0000", got_blank); end
    src_sel = 2'd3; set_src(3, 13'h0005);
    do_conv(lat);
    total++; if (got_digits !== 16'h0005) begin bad++; $display("FAIL hex_5_digits got=%h exp=0005", got_digits); end
    total++; if (got_blank !== 4'b0000) begin bad++; $display("FAIL hex_5_blank got=%b exp=0000", got_blank); end
  endtask

  task automatic test_min_max;
    int lat;
    src_sel = 2'd0; mode = 2'd2; set_src(0, 13'd500);
    do_conv(lat);
    total++; if (got_digits !== 16'h0500 || got_blank !== 4'b1000) begin bad++; $display("FAIL min_first got=%h/%b exp=0500/1000", got_digits, got_blank); end
    set_src(0, 13'd200);
    do_conv(lat);
    total++; if (got_digits !== 16'h0200) begin bad++; $display("FAIL min_200 got=%h exp=0200", got_digits); end
    mode = 2'd3; set_src(0, 13'd900);
    do_conv(lat);
    total++; if (got_digits !== 16'h0900) begin bad++; $display("FAIL max_900 got=%h exp=0900", got_digits); end
    mode = 2'd2;
    do_conv(lat);
    total++; if (got_digits !== 16'h0200) begin bad++; $display("FAIL min_keeps_200 got=%h exp=0200", got_digits); end
    pulse(1'b0, 1'b1);
    set_src(0, 13'd300);
    do_conv(lat);
    total++; if (got_digits !== 16'h0300) begin bad++; $display("FAIL min_after_clear got=%h exp=0300", got_digits); end
    mode = 2'd3;
    do_conv(lat);
    total++; if (got_digits !== 16'h0300) begin bad++; $display("FAIL max_after_clear got=%h exp=0300", got_digits); end
    mode = 2'd2; src_sel = 2'd1; set_src(1, 13'd450);
    do_conv(lat);
    total++; if (got_digits !== 16'h0450) begin bad++; $display("FAIL min_after_sel_change got=%h exp=0450", got_digits); end
  endtask

  task automatic test_hold;
    int lat;
    src_sel = 2'd0; mode = 2'd0; set_src(0, 13'd1000);
    pulse(1'b1, 1'b0);
    set_src(0, 13'd2000); mode = 2'd1;
    do_conv(lat);
    total++; if (got_digits !== 16'h1000) begin bad++; $display("FAIL hold_1000 got=%h exp=1000", got_digits); end
    mode = 2'd0;
    do_conv(lat);
    total++; if (got_digits !== 16'h2000) begin bad++; $display("FAIL live_2000 got=%h exp=2000", got_digits); end
    set_src(0, 13'd2500);
    pulse(1'b1, 1'b1);
    set_src(0, 13'd2600); mode = 2'd1;
    do_conv(lat);
    total++; if (got_digits !== 16'h2500) begin bad++; $display("FAIL hold_with_clear got=%h exp=2500", got_digits); end
    mode = 2'd2;
    do_conv(lat);
    total++; if (got_digits !== 16'h2600) begin bad++; $display("FAIL min_with_hold got=%h exp=2600", got_digits); end
  endtask

  task automatic test_reset_mid;
    int lat, n;
    src_sel = 2'd0; mode = 2'd0; set_src(0, 13'd4321);
    n = 0;
    while ((cyc % 32) != 31 && n < 64) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_shift got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if (digits !== 16'h0 || blank !== 4'b1110) begin bad++; $display("FAIL mid_reset_out got=%h/%b exp=0000/1110", digits, blank); end
    total++; if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL mid_reset_flags got busy=%b valid=%b ovf=%b exp 0 0 0", busy, valid, ovf); end
    @(negedge clk);
    reset_n = 1'b1;
    do_conv(lat);
    total++; if (lat !== 15 || got_digits !== 16'h4321 || got_blank !== 4'b0000) begin bad++; $display("FAIL after_reset_conv got lat=%0d %h/%b exp 15 4321/0000", lat, got_digits, got_blank); end
    mode = 2'd1;
    do_conv(lat);
    total++; if (got_digits !== 16'h0000 || got_blank !== 4'b1110) begin bad++; $display("FAIL snapshot_after_reset got=%h/%b exp=0000/1110", got_digits, got_blank); end
  endtask

  task automatic test_overflow;
    int lat, vcount;
    logic busy8;
    src_data3[12:0] = 13'd8191;
    do_conv3(lat, vcount, busy8);
    total++; if (vcount !== 1) begin bad++; $display("FAIL ovf_valid_count got=%0d exp=1", vcount); end
    total++; if (lat !== 15) begin bad++; $display("FAIL ovf_latency got=%0d exp=15", lat); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL ovf_busy_at_dropped_tick got=%b exp=1", busy8); end
    total++; if (got3_digits !== 12'h191 || got3_blank !== 3'b000 || got3_ovf !== 1'b1) begin bad++; $display("FAIL ovf_8191 got=%h/%b/%b exp=191/000/1", got3_digits, got3_blank, got3_ovf); end
    src_data3[12:0] = 13'd999;
    do_conv3(lat, vcount, busy8);
    total++; if (got3_digits !== 12'h999 || got3_blank !== 3'b000 || got3_ovf !== 1'b0) begin bad++; $display("FAIL d3_999 got=%h/%b/%b exp=999/000/0", got3_digits, got3_blank, got3_ovf); end
    src_data3[12:0] = 13'd42;
    do_conv3(lat, vcount, busy8);
    total++; if (got3_digits !== 12'h042 || got3_blank !== 3'b100 || got3_ovf !== 1'b0) begin bad++; $display("FAIL d3_42 got=%h/%b/%b exp=042/100/0", got3_digits, got3_blank, got3_ovf); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n     = 1'b0;
    src_data    = '0;
    src_sel     = 2'd0;
    mode        = 2'd0;
    hold_pulse  = 1'b0;
    clear_pulse = 1'b0;
    src_data3   = '0;
    src_sel3    = 2'd0;
    mode3       = 2'd0;
    hold3       = 1'b0;
    clear3      = 1'b0;
    @(negedge clk);
    test_reset();
    test_decimal_live();
    test_hex();
    test_min_max();
    test_hold();
    test_reset_mid();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_source_display_ctrl.md
# multi_source_display_ctrl

Parametrised display front end that replaces the fixed two-level source mux, 16-bit capture register and free-running binary-to-BCD path with one sequential block. It selects one of `NUM_SRC` measurement sources and shows either its live value, a button-captured snapshot, or its running minimum or maximum. It converts the value to hex nibbles or decimal BCD on a fixed refresh tick and drives per-digit leading-zero blanking. It sits between the ADC/synchroniser/debounce blocks and the seven-segment digit manager.

## Interface
Parameters:
- `NUM_SRC`, 4: number of input sources (≥2).
- `DATA_W`, 13: width of each source value.
- `NUM_DIGITS`, 4: number of 4-bit output digits.
- `DEC_MASK`, 4'b0011: bit i = 1 means source i is shown in decimal; 0 means hex.
- `UPDATE_DIV`, 32: refresh tick period in clocks. Must be ≥ `DATA_W`+4.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `src_data`  in  `NUM_SRC*DATA_W`  packed sources; source i occupies `[i*DATA_W +: DATA_W]`.
- `src_sel`  in  `$clog2(NUM_SRC)`  source select, already synchronised. Values ≥ `NUM_SRC` select source 0.
- `mode`  in  2  0 LIVE, 1 HOLD, 2 MIN, 3 MAX; sampled on tick.
- `hold_pulse`  in  1  one-cycle debounced capture strobe.
- `clear_pulse`  in  1  one-cycle strobe that restarts min/max tracking.
- `digits`  out  `NUM_DIGITS*4`  digit nibbles, digit 0 least significant.
- `blank`  out  `NUM_DIGITS`  per-digit blank, active high.
- `valid`  out  1  one-cycle pulse when `digits`/`blank` update.
- `busy`  out  1  high while a conversion is in progress.
- `ovf`  out  1  decimal value exceeds 10^`NUM_DIGITS`−1.

## Operation
- Live value = selected source slice, taken combinationally.
- Snapshot register: loads the live value on `hold_pulse`; otherwise holds.
- Min/max: `first` flag is set by reset, by `clear_pulse`, or by a change of the registered `src_sel`. On each tick:
  - If `first` is set: min = max = live value, then clear `first`.
  - Otherwise: min = min(min, live) and max = max(max, live), unsigned compare.
- Displayed value on tick: LIVE gives live, HOLD gives snapshot, MIN gives min, MAX gives max.
- FSM states `IDLE`, `SHIFT`, `DONE`:
  - `IDLE`, on tick: latch the displayed value and the decimal/hex mode. Hex goes to `DONE`. Decimal clears the BCD accumulator and goes to `SHIFT`.
  - `SHIFT`: one double-dabble step per cycle (add 3 to every BCD nibble ≥5, then shift left one bit). After exactly `DATA_W` steps, go to `DONE`.
  - `DONE`: write `digits`, `blank` and `ovf`; pulse `valid`; return to `IDLE`.
- Hex format:
  - `digits` = zero-extended value nibbles.
  - `blank[i]` = 1 only for i ≥ ceil(`DATA_W`/4).
  - `ovf` = 0.
- Decimal format:
  - `digits` = the low `NUM_DIGITS` BCD digits.
  - Leading-zero blanking applies above the most significant nonzero digit. Digit 0 is never blanked.
  - `ovf` = 1 if any higher BCD digit is nonzero. In that case there is no blanking.
- `busy` = 1 in `SHIFT` and `DONE`.
- Simultaneous events:
  - A tick arriving while not in `IDLE` is dropped.
  - `hold_pulse` and `clear_pulse` in the same cycle both take effect.
  - `clear_pulse` on a tick cycle: that tick already uses `first`=1.

## Timing
- Tick counter runs 0..`UPDATE_DIV`−1 from reset; tick is asserted when the counter = `UPDATE_DIV`−1.
- Latency from tick to `valid`:
  - Hex: 2 cycles.
  - Decimal: `DATA_W`+2 cycles.
- Outputs are registered and change only in the `DONE` cycle.
- Reset values: `digits`=0, `blank`=all ones except bit 0, `valid`=0, `busy`=0, `ovf`=0. Snapshot, min, max and tick counter are 0; `first`=1; FSM is `IDLE`.
- Reset asserted mid-conversion forces the reset values immediately and abandons the partial conversion.

## Structure
- `display_pkg`: `mode_e` enum (LIVE/HOLD/MIN/MAX), `conv_state_e` enum, and a `BCD_DIGITS(w)` constant function returning ceil(w·log10 2).
- Sub-module `bcd_iter`: iterative double-dabble with ports `start`, `bin`, `bcd`, `done`, parametrised on width. The FSM wraps it.

## Test plan
Base parameters for scenarios 1–5: `NUM_SRC`=4, `DATA_W`=13, `NUM_DIGITS`=4, `DEC_MASK`=4'b0011, `UPDATE_DIV`=32.
1. Reset released, src0=1234, LIVE → `valid` at tick+15; `digits`=16'h1234, `blank`=4'b0000, `ovf`=0. src0=7 → `digits`=16'h0007, `blank`=4'b1110.
2. `src_sel`=2, src2=13'h0ABC, LIVE → `digits`=16'h0ABC, `blank`=0, `valid` at tick+2.
3. src0 = 500, 200, 900 on successive ticks → MIN shows 16'h0200, MAX shows 16'h0900. Then `clear_pulse`, src0=300 → MIN and MAX both show 16'h0300. Changing `src_sel` has the same restart effect.
4. src0=1000, `hold_pulse`, then src0=2000 → HOLD shows 16'h1000, LIVE shows 16'h2000.
5. `reset_n` low at tick+6 → outputs take reset values that cycle. The next tick converts afresh with correct digits.
6. Overflow and sequencing, with `NUM_DIGITS`=3: src0=8191 → `ovf`=1, `digits`=12'h191, `blank`=0. A second tick arriving during `SHIFT` is ignored, giving exactly one `valid` pulse.
